// File: rtl/stack_sequencer.sv
// Byte/word stack sequencer for the Ra8 core: drives the external stack pointer strobes
// and an 8-bit memory port, with bounds checking done once at command acceptance.
//
// state | meaning
// IDLE  | ready for a command
// LOAD  | sp_load pulse with the captured value
// DEC   | pre-decrement SP ahead of a push write
// WRITE | byte write at sp, held until mem_ack
// READ  | byte read at sp, held until mem_ack
// INC   | post-increment SP after a pop read
// RESP  | one-cycle response pulse
module stack_sequencer #(
   parameter logic [15:0] STACK_TOP   = 16'h0100,
   parameter logic [15:0] STACK_LIMIT = 16'h0080
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [15:0] cmd_data,
   input  logic [15:0] sp,
   output logic        sp_load,
   output logic        sp_enable,
   output logic        sp_pop,
   output logic [15:0] sp_inAddr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_err
);
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_DEC, S_WRITE, S_READ, S_INC, S_RESP
   } state_t;

   localparam logic [2:0] OP_LOAD   = 3'd0;
   localparam logic [2:0] OP_PUSH8  = 3'd1;
   localparam logic [2:0] OP_POP8   = 3'd2;
   localparam logic [2:0] OP_PUSH16 = 3'd3;
   localparam logic [2:0] OP_POP16  = 3'd4;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [15:0] data_q, data_d;
   logic [1:0]  n_q, n_d;
   logic [15:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [1:0]  cmd_n;
   logic [16:0] sp_x, n_x;
   logic        push_err, pop_err;

   // 17-bit compares so an SP near either end of the address space cannot wrap
   assign cmd_n    = (cmd_op == OP_PUSH16 || cmd_op == OP_POP16) ? 2'd2 : 2'd1;
   assign sp_x     = {1'b0, sp};
   assign n_x      = {15'd0, cmd_n};
   assign push_err = sp_x < ({1'b0, STACK_LIMIT} + n_x);
   assign pop_err  = (sp_x + n_x) > {1'b0, STACK_TOP};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q    <= 3'd0;
         data_q  <= 16'd0;
         n_q     <= 2'd0;
         rdata_q <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         n_q     <= n_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      data_d    = data_q;
      n_d       = n_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      cmd_ready = 1'b0;
      sp_load   = 1'b0;
      sp_enable = 1'b0;
      sp_pop    = 1'b0;
      sp_inAddr = 16'd0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 16'd0;
      mem_wdata = 8'd0;
      rsp_valid = 1'b0;
      rsp_data  = 16'd0;
      rsp_err   = 1'b0;

      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_d    = cmd_op;
               data_d  = cmd_data;
               n_d     = cmd_n;
               rdata_d = 16'd0;
               err_d   = 1'b0;
               case (cmd_op)
                  OP_LOAD: state_d = S_LOAD;
                  OP_PUSH8, OP_PUSH16: begin
                     err_d   = push_err;
                     state_d = push_err ? S_RESP : S_DEC;
                  end
                  OP_POP8, OP_POP16: begin
                     err_d   = pop_err;
                     state_d = pop_err ? S_RESP : S_READ;
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = S_RESP;
                  end
               endcase
            end
         end
         S_LOAD: begin
            sp_load   = 1'b1;
            sp_inAddr = data_q;
            state_d   = S_RESP;
         end
         S_DEC: begin
            sp_enable = 1'b1;
            state_d   = S_WRITE;
         end
         S_WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sp;
            // high byte goes first so the low byte lands at the lower address
            mem_wdata = (n_q == 2'd2) ? data_q[15:8] : data_q[7:0];
            if (mem_ack) begin
               if (n_q == 2'd2) begin
                  n_d     = 2'd1;
                  state_d = S_DEC;
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_READ: begin
            mem_req  = 1'b1;
            mem_addr = sp;
            if (mem_ack) begin
               if (op_q == OP_POP16 && n_q == 2'd1) rdata_d[15:8] = mem_rdata;
               else                                 rdata_d[7:0]  = mem_rdata;
               state_d = S_INC;
            end
         end
         S_INC: begin
            sp_enable = 1'b1;
            sp_pop    = 1'b1;
            if (n_q == 2'd2) begin
               n_d     = 2'd1;
               state_d = S_READ;
            end else begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            rsp_data  = rdata_q;
            rsp_err   = err_q;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: stack pointer and byte memory models around the DUT, with a
// byte-level stack reference model predicting sp, memory, response and latency per command.
module tb_stack_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = 3'd0;
   logic [15:0] cmd_data = 16'd0;
   logic [15:0] sp_r = 16'h0100;
   logic        sp_load, sp_enable, sp_pop;
   logic [15:0] sp_inAddr;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        rsp_valid, rsp_err;
   logic [15:0] rsp_data;

   bit [7:0] tb_mem [0:65535];
   bit [7:0] mem_m  [0:65535];
   int       wcnt = 0;
   int       ack_delay = 0;
   int       sp_m = 'h100;
   int       checks = 0;
   int       errors = 0;

   stack_sequencer dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .sp(sp_r),
      .sp_load(sp_load), .sp_enable(sp_enable), .sp_pop(sp_pop), .sp_inAddr(sp_inAddr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   // external stack pointer register and memory with programmable ack delay
   assign mem_ack   = mem_req && (wcnt == ack_delay);
   assign mem_rdata = tb_mem[mem_addr];

   always @(posedge clk) begin
      if (sp_load)        sp_r <= sp_inAddr;
      else if (sp_enable) sp_r <= sp_pop ? sp_r + 16'd1 : sp_r - 16'd1;
      if (mem_req && !mem_ack) wcnt <= wcnt + 1;
      else                     wcnt <= 0;
      if (mem_req && mem_ack && mem_we) tb_mem[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [15:0] data, input int w,
                          input bit hold);
      int n, lat_e, got, loads, decs, incs, eloads, edecs, eincs, viol;
      bit push, pop, err_e, pv, pa;
      logic [15:0] rd_e, paddr;
      logic [7:0]  pwd;
      n    = (op == 3 || op == 4) ? 2 : 1;
      push = (op == 1 || op == 3);
      pop  = (op == 2 || op == 4);
      err_e = (op > 4) || (push && sp_m - n < 'h80) || (pop && sp_m + n > 'h100);
      rd_e = 16'h0000;
      eloads = 0; edecs = 0; eincs = 0;
      if (err_e) begin
         lat_e = 1;
      end else if (op == 0) begin
         lat_e = 2; eloads = 1; sp_m = int'(data);
      end else begin
         lat_e = 2 * n + 1 + n * w;
         if (push) begin
            edecs = n;
            if (n == 2) begin
               sp_m--; mem_m[sp_m] = data[15:8];
            end
            sp_m--; mem_m[sp_m] = data[7:0];
         end else begin
            eincs = n;
            rd_e[7:0] = mem_m[sp_m];
            if (n == 2) rd_e[15:8] = mem_m[sp_m + 1];
            sp_m += n;
         end
      end

      ack_delay = w;
      @(negedge clk);
      chk("ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
      @(posedge clk);
      got = -1; loads = 0; decs = 0; incs = 0; viol = 0; pv = 0; pa = 0;
      paddr = 16'd0; pwd = 8'd0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (hold) begin
            cmd_op = 3'($urandom_range(0, 7)); cmd_data = 16'($urandom);
         end else begin
            cmd_valid = 1'b0;
         end
         loads += int'(sp_load);
         if (sp_enable && sp_pop)  incs++;
         if (sp_enable && !sp_pop) decs++;
         if (int'(sp_load) + int'(sp_enable) > 1) viol++;
         if (cmd_ready) viol++;
         if (mem_req && mem_addr !== sp_r) viol++;
         if (pv && !pa && mem_req && (mem_addr !== paddr || mem_wdata !== pwd)) viol++;
         pv = mem_req; pa = mem_ack; paddr = mem_addr; pwd = mem_wdata;
         if (rsp_valid) begin
            got = k;
            cmd_valid = 1'b0;
            break;
         end
      end
      chk("latency", 32'(got), 32'(lat_e));
      chk("rsp_err", 32'(rsp_err), 32'(err_e));
      chk("rsp_data", 32'(rsp_data), 32'(rd_e));
      chk("sp_after", 32'(sp_r), 32'(sp_m));
      chk("strobes", {8'd0, 8'(loads), 8'(decs), 8'(incs)},
          {8'd0, 8'(eloads), 8'(edecs), 8'(eincs)});
      chk("protocol", 32'(viol), 32'd0);
      if (push && !err_e) begin
         chk("mem_lo", 32'(tb_mem[sp_m]), 32'(mem_m[sp_m]));
         if (n == 2) chk("mem_hi", 32'(tb_mem[sp_m + 1]), 32'(mem_m[sp_m + 1]));
      end
      cmd_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_outs"},
          {26'd0, mem_req, sp_load, sp_enable, sp_pop, rsp_valid, rsp_err}, 32'd0);
      chk({tag, "_buses"}, {rsp_data, sp_inAddr}, 32'd0);
   endtask

   initial begin
      int spin;
      logic [2:0] rop;
      repeat (3) @(negedge clk);
      chk_reset_outputs("por");
      reset = 1'b1;

      run_cmd(3'd0, 16'h0100, 0, 0);

      // abandon a PUSH16 while its first write is stalled
      ack_delay = 20;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd3; cmd_data = 16'hBEEF;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      spin = 0;
      while (!mem_req && spin < 10) begin
         @(negedge clk);
         spin++;
      end
      chk("reach_write", 32'(mem_req), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_reset_outputs("midop");
      sp_m = sp_m - 1;
      chk("sp_midop", 32'(sp_r), 32'(sp_m));
      chk("no_write", 32'(tb_mem[16'h00FF]), 32'(mem_m[16'h00FF]));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      ack_delay = 0;

      run_cmd(3'd0, 16'h0100, 0, 0);
      run_cmd(3'd1, 16'h00A5, 0, 0);
      run_cmd(3'd0, 16'h0100, 0, 0);
      run_cmd(3'd3, 16'h1234, 0, 0);
      run_cmd(3'd4, 16'h0000, 0, 0);
      run_cmd(3'd1, 16'h005A, 3, 0);
      run_cmd(3'd0, 16'h0100, 0, 0);
      run_cmd(3'd2, 16'h0000, 0, 0);
      run_cmd(3'd0, 16'h0081, 0, 0);
      run_cmd(3'd3, 16'hCAFE, 0, 0);
      run_cmd(3'd1, 16'h0077, 0, 0);
      run_cmd(3'd7, 16'hFFFF, 0, 1);
      run_cmd(3'd0, 16'h0090, 0, 1);
      run_cmd(3'd3, 16'hA1B2, 1, 1);
      run_cmd(3'd4, 16'h0000, 2, 1);

      for (int i = 0; i < 80; i++) begin
         spin = int'($urandom_range(0, 15));
         if (spin < 2)       rop = 3'd0;
         else if (spin < 5)  rop = 3'd1;
         else if (spin < 8)  rop = 3'd2;
         else if (spin < 11) rop = 3'd3;
         else if (spin < 14) rop = 3'd4;
         else                rop = 3'($urandom_range(5, 7));
         if (rop == 3'd0)
            run_cmd(rop, 16'($urandom_range(16'h007E, 16'h0102)), 0, 0);
         else
            run_cmd(rop, 16'($urandom), int'($urandom_range(0, 2)), $urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
